vctr_rx_fifo: RTL and testbench

Parametrised UART receiver with an integrated receive FIFO. It is the next-generation receive front end of the vctr vector path. Width, oversampling, parity and stop-bit count are configurable. It adds start-bit validation, frame/parity/overflow error reporting, and a first-word-fall-through (FWFT) valid/ready output. Received words feed the vector output logic directly, with no external buffering.

---
 rtl/vctr_rx_fifo.sv | 248 ++++++++++++++++++++++++
 tb/tb_vctr_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vctr_rx_fifo.sv
// vctr_rx_fifo: oversampling UART receiver with start-bit validation,
// frame/parity/overflow error pulses and a first-word-fall-through receive
// FIFO presented as a valid/ready stream.
module vctr_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          rx_valid,
    output logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_W + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_M1  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_M1  = BW'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Received word plus parity bit is acceptable for the configured mode.
    function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
        logic ok;
        case (PARITY)
            1:       ok = ((^d) ^ p) == 1'b1;
            2:       ok = ((^d) ^ p) == 1'b0;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Receiver state
    logic              rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              push_q, push_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              tick_s, stop_tick_s, last_stop_s, par_good_s;

    // FIFO state
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]     count_q, count_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              overflow_q, overflow_d;
    logic              pop_s, full_s, wr_en_s;

    // Sample point: half a bit into START, then one full bit period apart.
    assign tick_s = (state_q == S_START) ? (cnt_q == HALF_M1) : (cnt_q == BIT_M1);

    // State register, datapath registers and the two-flop synchroniser.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            bit_q        <= {BW{1'b0}};
            shift_q      <= {DATA_W{1'b0}};
            par_q        <= 1'b0;
            push_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {NW{1'b0}};
            rx_valid_q   <= 1'b0;
            rx_data_q    <= {DATA_W{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            push_q       <= push_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Next-state logic for the frame FSM and its bit/clock counters.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (!rx_s_q) begin
                    state_d = S_START;
                    bit_d   = {BW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (bit_q == DATA_M1) begin
                        bit_d   = {BW{1'b0}};
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    cnt_d   = {CW{1'b0}};
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    cnt_d = {CW{1'b0}};
                    if (!rx_s_q) begin
                        state_d = S_WAIT_IDLE;
                    end else if (bit_q == STOP_M1) begin
                        bit_d   = {BW{1'b0}};
                        state_d = S_IDLE;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not look like a new start bit.
                cnt_d   = {CW{1'b0}};
                state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
            end
            default: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame outcome: error pulses and push request, registered next cycle.
    always_comb begin
        stop_tick_s  = (state_q == S_STOP) && tick_s;
        last_stop_s  = stop_tick_s && rx_s_q && (bit_q == STOP_M1);
        par_good_s   = parity_ok(shift_q, par_q);
        frame_err_d  = stop_tick_s && !rx_s_q;
        parity_err_d = last_stop_s && !par_good_s;
        push_d       = last_stop_s && par_good_s;
        busy_d       = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; shift_q still holds the pushed word in the push cycle.
    always_comb begin
        pop_s      = rx_valid_q && rx_ready;
        full_s     = (count_q == FULL_CNT);
        wr_en_s    = push_q && (!full_s || pop_s);
        overflow_d = push_q && full_s && !pop_s;
        wr_ptr_d   = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        rx_valid_d = (count_d != {NW{1'b0}});
        if (count_d == {NW{1'b0}}) begin
            rx_data_d = rx_data_q;
        end else if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
            rx_data_d = shift_q;
        end else begin
            rx_data_d = mem_q[rd_ptr_d];
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vctr_rx_fifo.sv
// Directed testbench for vctr_rx_fifo: a default instance (no parity) and an
// even-parity instance share the clock and reset.
module tb_vctr_rx_fifo;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clock = 1'b0;
    logic       rst;
    logic       rx0, rx1, ready0, ready1;
    logic       valid0, valid1, busy0, busy1;
    logic       ferr0, ferr1, perr0, perr1, ovf0, ovf1;
    logic [7:0] data0, data1;
    logic [4:0] cnt0, cnt1;

    vctr_rx_fifo u_dut (
        .clock(clock), .rst(rst), .rx(rx0),
        .rx_valid(valid0), .rx_data(data0), .rx_ready(ready0),
        .fifo_count(cnt0), .busy(busy0),
        .frame_err(ferr0), .parity_err(perr0), .overflow(ovf0)
    );

    vctr_rx_fifo #(.PARITY(2)) u_dut_par (
        .clock(clock), .rst(rst), .rx(rx1),
        .rx_valid(valid1), .rx_data(data1), .rx_ready(ready1),
        .fifo_count(cnt1), .busy(busy1),
        .frame_err(ferr1), .parity_err(perr1), .overflow(ovf1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int vld0 = 0, fe0 = 0, pe0 = 0, ov0 = 0, rise0 = 0, popn0 = 0;
    int vld1 = 0, fe1 = 0, pe1 = 0, ov1 = 0, popn1 = 0;
    logic       pv0 = 1'b0;
    logic [7:0] plog0 [0:127];
    logic [7:0] plog1 [0:127];

    always @(negedge clock) begin
        pv0  <= valid0;
        if (valid0 && !pv0) rise0 <= cyc;
        vld0 <= vld0 + int'(valid0);
        fe0  <= fe0 + int'(ferr0);
        pe0  <= pe0 + int'(perr0);
        ov0  <= ov0 + int'(ovf0);
        vld1 <= vld1 + int'(valid1);
        fe1  <= fe1 + int'(ferr1);
        pe1  <= pe1 + int'(perr1);
        ov1  <= ov1 + int'(ovf1);
        if (valid0 && ready0) begin
            plog0[popn0] <= data0;
            popn0        <= popn0 + 1;
        end
        if (valid1 && ready1) begin
            plog1[popn1] <= data1;
            popn1        <= popn1 + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive n bits LSB first, one bit period each, onto the selected line.
    task automatic send(input bit which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which) rx1 = bits[i];
            else       rx0 = bits[i];
            idle(CPB);
        end
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        return {6'b000000, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] framep(input logic [7:0] d, input logic p);
        return {5'b00000, 1'b1, p, d, 1'b0};
    endfunction

    int s_vld, s_fe, s_pe, s_ov, s_pop, s_pe1, s_pop1, s_fe1, t0, base;
    bit dropped;

    task automatic snap();
        s_vld = vld0; s_fe = fe0; s_pe = pe0; s_ov = ov0; s_pop = popn0;
        s_pe1 = pe1; s_pop1 = popn1; s_fe1 = fe1;
    endtask

    function automatic int err_delta();
        return (fe0 - s_fe) + (pe0 - s_pe) + (ov0 - s_ov);
    endfunction

    initial begin
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        idle(3);
        rst = 1'b0;
        check_val("rst_valid", valid0, 1'b0);
        check_val("rst_data",  data0, 8'h00);
        check_val("rst_count", cnt0, 5'd0);
        check_val("rst_busy",  busy0, 1'b0);
        check_val("rst_errs",  {ferr0, perr0, ovf0}, 3'b000);

        // Single 0xA5 frame, consumer always ready.
        ready0 = 1'b1;
        idle(2);
        snap();
        t0 = cyc + 1;
        send(1'b0, frame8(8'hA5, 1'b1), 10);
        idle(20);
        check_val("a5_rise_cycle", rise0, t0 + 155);
        check_val("a5_valid_len",  vld0 - s_vld, 1);
        check_val("a5_data",       plog0[popn0-1], 8'hA5);
        check_val("a5_errs",       err_delta(), 0);

        // False start: line low for 4 cycles only.
        snap();
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        check_val("fs_busy_high", busy0, 1'b1);
        dropped = 1'b0;
        for (int i = 0; i < HALF + 3 && !dropped; i++) begin
            @(negedge clock);
            if (!busy0) dropped = 1'b1;
        end
        check_val("fs_busy_drop", dropped, 1'b1);
        @(posedge clock);
        #1;
        idle(20);
        check_val("fs_no_push", vld0 - s_vld, 0);
        check_val("fs_errs",    err_delta(), 0);

        // Stop bit held low (break), then a good 0x55 frame.
        snap();
        send(1'b0, frame8(8'h3C, 1'b0), 10);
        idle(200);
        check_val("fr_wait_busy", busy0, 1'b1);
        check_val("fr_ferr",      fe0 - s_fe, 1);
        check_val("fr_count",     cnt0, 5'd0);
        rx0 = 1'b1;
        idle(10);
        check_val("fr_idle",      busy0, 1'b0);
        send(1'b0, frame8(8'h55, 1'b1), 10);
        idle(20);
        check_val("fr_next_data", plog0[popn0-1], 8'h55);
        check_val("fr_pops",      popn0 - s_pop, 1);
        check_val("fr_errs",      err_delta(), 1);

        // Even parity instance: bad then good parity on 0x07.
        ready1 = 1'b1;
        snap();
        send(1'b1, framep(8'h07, 1'b0), 11);
        idle(20);
        check_val("par_err",     pe1 - s_pe1, 1);
        check_val("par_no_push", popn1 - s_pop1, 0);
        check_val("par_count",   cnt1, 5'd0);
        send(1'b1, framep(8'h07, 1'b1), 11);
        idle(20);
        check_val("par_ok_push", popn1 - s_pop1, 1);
        check_val("par_ok_data", plog1[popn1-1], 8'h07);
        check_val("par_err_one", pe1 - s_pe1, 1);
        check_val("par_ferr",    fe1 - s_fe1, 0);

        // Fill to 16, overflow on the 17th, then drain in order.
        ready0 = 1'b0;
        snap();
        for (int i = 0; i < 16; i++) send(1'b0, frame8(8'(i), 1'b1), 10);
        idle(5);
        check_val("full_count", cnt0, 5'd16);
        check_val("full_no_ov", ov0 - s_ov, 0);
        send(1'b0, frame8(8'h10, 1'b1), 10);
        idle(5);
        check_val("ov_count", cnt0, 5'd16);
        check_val("ov_pulse", ov0 - s_ov, 1);
        check_val("ov_head",  data0, 8'h00);
        base = popn0;
        ready0 = 1'b1;
        idle(30);
        check_val("drain_pops", popn0 - base, 16);
        for (int i = 0; i < 16; i++) check_val("drain_order", plog0[base+i], 32'(i));
        check_val("drain_valid", valid0, 1'b0);
        check_val("drain_count", cnt0, 5'd0);

        // Full FIFO: pop in the same cycle the next word is pushed.
        ready0 = 1'b0;
        snap();
        for (int i = 0; i < 16; i++) send(1'b0, frame8(8'(8'h20 + i), 1'b1), 10);
        idle(5);
        base = popn0;
        t0 = cyc + 1;
        fork
            send(1'b0, frame8(8'h30, 1'b1), 10);
            begin
                repeat (155) @(posedge clock);
                #1 ready0 = 1'b1;
                @(posedge clock);
                #1 ready0 = 1'b0;
            end
        join
        idle(5);
        check_val("sim_count", cnt0, 5'd16);
        check_val("sim_no_ov", ov0 - s_ov, 0);
        check_val("sim_popped", plog0[base], 8'h20);
        check_val("sim_head",  data0, 8'h21);
        ready0 = 1'b1;
        idle(30);
        check_val("sim_pops", popn0 - base, 17);
        check_val("sim_last", plog0[base+16], 8'h30);
        check_val("sim_empty", cnt0, 5'd0);

        // Reset in the middle of DATA with a word stored.
        ready0 = 1'b0;
        send(1'b0, frame8(8'h5A, 1'b1), 10);
        idle(5);
        check_val("mr_setup_count", cnt0, 5'd1);
        rx0 = 1'b0;
        idle(40);
        check_val("mr_busy_pre", busy0, 1'b1);
        rst = 1'b1;
        rx0 = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("mr_valid", valid0, 1'b0);
        check_val("mr_data",  data0, 8'h00);
        check_val("mr_count", cnt0, 5'd0);
        check_val("mr_busy",  {busy0, busy1}, 2'b00);
        idle(10);
        snap();
        ready0 = 1'b1;
        send(1'b0, frame8(8'h99, 1'b1), 10);
        idle(20);
        check_val("mr_next_pops", popn0 - s_pop, 1);
        check_val("mr_next_data", plog0[popn0-1], 8'h99);
        check_val("mr_next_errs", err_delta() + (ov1 + vld1 - vld1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
